// File: rtl/moore_over_1011.sv
// moore_over_1011
//   Moore FSM detecting the serial pattern 1011 on a 1-bit stream, overlaps
//   allowed. One bit is consumed on every rising clock edge. out is high for
//   exactly one cycle per completed match and is decoded from the state
//   register only.
//
// Optional feature (macro MOORE_MATCH_CNT_EN):
//   Adds parameter CNT_W (default 8) and output match_cnt, a saturating count
//   of detected matches. Without the macro the port list is clk, rst, in, out.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-low (rst==0 resets)
//   in         in   1      serial data bit
//   out        out  1      high while the FSM sits in S4 (1011 just seen)
//   match_cnt  out  CNT_W  saturating match count (MOORE_MATCH_CNT_EN only)
module moore_over_1011
`ifdef MOORE_MATCH_CNT_EN
#(
    parameter int unsigned CNT_W = 8
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic             out
`ifdef MOORE_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    typedef enum logic [2:0] {
        S0 = 3'b000,   // no prefix
        S1 = 3'b001,   // seen "1"
        S2 = 3'b010,   // seen "10"
        S3 = 3'b011,   // seen "101"
        S4 = 3'b100    // seen "1011"
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S0;
        case (state)
            S0:      state_next = in ? S1 : S0;
            S1:      state_next = in ? S1 : S2;
            S2:      state_next = in ? S3 : S0;
            S3:      state_next = in ? S4 : S2;
            // Trailing 1 of a match is reused as the start of the next one.
            S4:      state_next = in ? S1 : S2;
            // Unused encodings recover to idle.
            default: state_next = S0;
        endcase
    end

    assign out = (state == S4);

`ifdef MOORE_MATCH_CNT_EN
    // Counts on the edge that enters S4, so it updates together with out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
        end else if ((state_next == S4) && (match_cnt != '1)) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_moore_over_1011.sv
// tb_moore_over_1011
//   Self-checking bench for moore_over_1011. The reference model keeps the
//   history of bits received since reset and derives the expected state as
//   the length of the longest suffix of that history which is a prefix of
//   1011; a full-length match means out=1.
module tb_moore_over_1011;

    localparam int TB_CNT_W = 2;

    logic clk;
    logic rst;
    logic in;
    logic out;
`ifdef MOORE_MATCH_CNT_EN
    logic [TB_CNT_W-1:0] match_cnt;
`endif

    int checks;
    int failures;

    // Reference model state
    logic [3:0] hist;       // last four bits, newest in bit 0
    int         hist_len;   // bits received since reset (capped at 4)
    int         cnt_model;

`ifdef MOORE_MATCH_CNT_EN
    moore_over_1011 #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .out       (out),
        .match_cnt (match_cnt)
    );
`else
    moore_over_1011 dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Longest suffix of the received history that is a prefix of 1011.
    function automatic int prefix_len();
        logic [3:0] pat;
        logic [3:0] mask;
        for (int k = 4; k >= 1; k--) begin
            pat  = 4'b1011 >> (4 - k);
            mask = 4'hF >> (4 - k);
            if (hist_len >= k && (hist & mask) == pat) return k;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        hist      = '0;
        hist_len  = 0;
        cnt_model = 0;
    endfunction

    function automatic void model_push(input logic b);
        hist = {hist[2:0], b};
        if (hist_len < 4) hist_len++;
        if (prefix_len() == 4 && cnt_model < (1 << TB_CNT_W) - 1) cnt_model++;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int ps;
        ps = prefix_len();
        check({tag, "_out"}, 32'(out), (ps == 4) ? 32'd1 : 32'd0);
        check({tag, "_state"}, 32'(dut.state), 32'(ps));
`ifdef MOORE_MATCH_CNT_EN
        check({tag, "_cnt"}, 32'(match_cnt), 32'(cnt_model));
`endif
    endtask

    // Drive one bit, clock it in, then check. dir >= 0 also checks the
    // state against a hand-derived constant.
    task automatic step(input logic b, input string tag, input int dir);
        in = b;
        @(posedge clk);
        model_push(b);
        #1;
        check_all(tag);
        if (dir >= 0) check({tag, "_dir"}, 32'(dut.state), 32'(dir));
    endtask

    // Hold reset across two edges with in toggling.
    task automatic hold_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            in = ~in;
            @(posedge clk);
            #1;
            check("rst_hold", 32'(out), 32'd0);
            check("rst_hold_state", 32'(dut.state), 32'd0);
`ifdef MOORE_MATCH_CNT_EN
            check("rst_hold_cnt", 32'(match_cnt), 32'd0);
`endif
        end
        rst = 1'b1;
    endtask

    // Reset pulse between edges; effect must be immediate.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check({tag, "_out"}, 32'(out), 32'd0);
        check({tag, "_state"}, 32'(dut.state), 32'd0);
`ifdef MOORE_MATCH_CNT_EN
        check({tag, "_cnt"}, 32'(match_cnt), 32'd0);
`endif
        rst = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        in       = 1'b0;
        model_reset();
        #1;
        check("rst_t0_out", 32'(out), 32'd0);

        hold_reset();

        // Basic match followed by an overlapped match.
        step(1'b1, "basic1", 1);
        step(1'b0, "basic2", 2);
        step(1'b1, "basic3", 3);
        step(1'b1, "basic4", 4);
        check("basic4_pulse", 32'(out), 32'd1);
        step(1'b0, "basic5", 2);
        check("basic5_low", 32'(out), 32'd0);
        step(1'b1, "basic6", 3);
        step(1'b1, "basic7", 4);
        check("basic7_pulse", 32'(out), 32'd1);

        // Non-matching stream.
        step(1'b1, "nm1", 1);
        step(1'b1, "nm2", 1);
        step(1'b1, "nm3", 1);
        step(1'b0, "nm4", 2);
        step(1'b0, "nm5", 0);
        step(1'b1, "nm6", 1);
        step(1'b0, "nm7", 2);
        step(1'b1, "nm8", 3);
        step(1'b0, "nm9", 2);

        // Async reset mid-pattern discards the partial 101.
        step(1'b1, "ar1", 3);
        step(1'b0, "ar2", 2);
        step(1'b1, "ar3", 3);
        pulse_reset("ar_pulse");
        step(1'b1, "ar4", 1);
        check("ar4_no_match", 32'(out), 32'd0);

        // Repeated overlapped matches; exercises counter saturation.
        hold_reset();
        for (int i = 0; i < 16; i++) begin
            logic [15:0] stream;
            stream = 16'b1011011011011011;
            step(stream[15 - i], "ovl", -1);
        end
`ifdef MOORE_MATCH_CNT_EN
        check("cnt_saturated", 32'(match_cnt), 32'd3);
`endif
        // Reset while out is high drops it immediately.
        check("s4_before_pulse", 32'(out), 32'd1);
        pulse_reset("s4_pulse");

        // Random stream against the reference model.
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), "rand", -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
